instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- Sequential instruction encoder/program loader for the multicycle RISC-V core.
- Accepts decoded instruction fields (format class, registers, funct, immediate) over a valid/ready handshake and packs them into 32-bit RV32I words.
- Writes each word into instruction memory at an auto-incrementing word address.
- Inverse of the core's opcode/immediate-format decoding; used by the bench and boot path to build programs.

Parameters:
- ADDR_W, 8, instruction-memory word-address width; capacity DEPTH = 2**ADDR_W words.
- BASE_ADDR, 0, word address loaded on reset and on start.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle pulse: restart loading at BASE_ADDR, clear err and full.
- in_valid  input  1  field bundle valid.
- in_ready  output  1  encoder can accept a bundle.
- cls  input  3  format class (package constants).
- rd  input  5  destination register.
- rs1  input  5  source register 1.
- rs2  input  5  source register 2.
- funct3  input  3  funct3 field.
- funct7  input  7  funct7 field (R-type only).
- imm  input  21  signed immediate, byte offset for B/J.
- mem_we  output  1  instruction-memory write strobe, one cycle per word.
- mem_addr  output  ADDR_W  word address of the current write.
- mem_wdata  output  32  encoded instruction.
- count  output  ADDR_W+1  number of words written since reset/start.
- err  output  1  sticky: a rejected bundle was seen.
- full  output  1  memory region exhausted.

Behaviour:
- Reset values: in_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, count=0, err=0, full=0. FSM state is IDLE.
- FSM states: IDLE, ENC, WRITE, FULL.
- IDLE: in_ready=1. A transfer occurs on in_valid & in_ready; go to ENC and register all fields.
- ENC: in_ready=0. Encode the registered fields and range-check the immediate.
  - Legal: register mem_wdata and go to WRITE.
  - Illegal: set err and go to IDLE; nothing is written and the address is unchanged.
- WRITE: mem_we=1 for exactly one cycle with mem_addr and mem_wdata stable.
  - Next cycle: mem_addr+1 and count+1.
  - Next state is FULL if the written address was DEPTH-1, else IDLE.
- Latency: accept at cycle N, mem_we at cycle N+2. Throughput is one word per 3 cycles.
- FULL: in_ready=0, full=1. No wrap-around; mem_addr holds at DEPTH-1. Only start or reset leaves FULL.
- start (any state, highest priority after reset):
  - mem_addr=BASE_ADDR, count=0, err=0, full=0, go to IDLE.
  - Any bundle in ENC/WRITE is discarded with no mem_we.
  - start and in_valid in the same cycle: start wins, the bundle is not accepted.
- Class encodings, with opcode and field layout:
  - LOAD: 0000011, I-type.
  - ALUI: 0010011, I-type.
  - JALR: 1100111, I-type, funct3 forced to 000.
  - STORE: 0100011, S-type.
  - BRANCH: 1100011, B-type.
  - JAL: 1101111, J-type.
  - Field layouts per the RV32I base spec; unused fields are zero.
- Immediate legality:
  - I/S: value in [-2048, 2047].
  - B: value in [-4096, 4094] and imm[0]=0.
  - J: value in [-2^20, 2^20-2] and imm[0]=0.
  - imm bits above the format width must be sign copies, otherwise the bundle is illegal.
- Class codes R and 7 are illegal unless the optional feature below is enabled; class 7 is always illegal.
- Reset mid-write: the write is abandoned immediately (asynchronous); mem_we drops.

Optional Feature:
- Macro: INSTR_ENCODER_RTYPE_EN.
- With macro defined: class R encodes opcode 0110011 as funct7|rs2|rs1|funct3|rd|op, and imm is ignored.
- Without macro: class R sets err and nothing is written. funct7 is then unused.

Decomposition:
- Shared package riscv_isa_pkg holds:
  - Class codes CLS_LOAD=0, CLS_ALUI=1, CLS_JALR=2, CLS_BRANCH=3, CLS_STORE=4, CLS_JAL=5, CLS_R=6.
  - The seven 7-bit opcode constants, also reused by the decoder side.
- One sub-module is natural: imm_packer. It is combinational: class + imm in; 32-bit immediate bit-scatter plus legal flag out.
- The FSM, address counter and handshake stay in the top module.

Test Plan:
- ALUI, rd=5, rs1=0, f3=000, imm=10 -> mem_we at accept+2, mem_addr=0, mem_wdata=0x00A00293, count=1.
- STORE, rs1=2, rs2=5, f3=010, imm=8 -> 0x00512423; BRANCH, rs1=rs2=0, f3=000, imm=-4 -> 0xFE000EE3; JAL, rd=1, imm=8 -> 0x008000EF.
- BRANCH imm=3, then ALUI imm=4096 -> err=1, no mem_we, mem_addr unchanged. A subsequent legal bundle is still written with err=1.
- ADDR_W=2: five back-to-back bundles -> addresses 0..3 written, full=1 and in_ready=0 after the 4th, 5th not accepted. start -> mem_addr=0, full=0, in_ready=1.
- start asserted while in WRITE's preceding ENC cycle -> no mem_we, count=0. Reset pulse mid-WRITE -> mem_we=0 immediately, all outputs at reset values.
- Class R, funct7=0100000, rs2=3, rs1=2, f3=000, rd=1:
  - With INSTR_ENCODER_RTYPE_EN -> 0x403100B3.
  - Without -> err=1, no write.

Source files
------------

// File: rtl/riscv_isa_pkg.sv
// Shared RV32I encoding constants for the encoder and the decoder side.
// Holds the format class codes, base opcodes, encoder FSM states and the field bundle.
package riscv_isa_pkg;

  localparam logic [2:0] CLS_LOAD   = 3'd0;
  localparam logic [2:0] CLS_ALUI   = 3'd1;
  localparam logic [2:0] CLS_JALR   = 3'd2;
  localparam logic [2:0] CLS_BRANCH = 3'd3;
  localparam logic [2:0] CLS_STORE  = 3'd4;
  localparam logic [2:0] CLS_JAL    = 3'd5;
  localparam logic [2:0] CLS_R      = 3'd6;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_ALUI   = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_R      = 7'b0110011;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ENC,
    ST_WRITE,
    ST_FULL
  } enc_state_t;

  typedef struct packed {
    logic [2:0]  cls;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [20:0] imm;
  } enc_fields_t;

  // Class 7 has no opcode and maps to zero.
  function automatic logic [6:0] cls_opcode(input logic [2:0] cls);
    logic [6:0] op;
    case (cls)
      CLS_LOAD:   op = OP_LOAD;
      CLS_ALUI:   op = OP_ALUI;
      CLS_JALR:   op = OP_JALR;
      CLS_BRANCH: op = OP_BRANCH;
      CLS_STORE:  op = OP_STORE;
      CLS_JAL:    op = OP_JAL;
      CLS_R:      op = OP_R;
      default:    op = 7'b0000000;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/instr_encoder_imm_packer.sv
// Scatters a signed immediate into its RV32I instruction bit positions and range-checks it.
// Class R is legal only when INSTR_ENCODER_RTYPE_EN is defined.
module imm_packer
  import riscv_isa_pkg::*;
(
  input  logic [2:0]  cls,
  input  logic [20:0] imm,
  output logic [31:0] imm_bits,
  output logic        legal
);

  logic fits12;
  logic fits13;

  // Every bit above the format's sign bit must be a copy of that sign bit.
  assign fits12 = (imm[20:11] == {10{imm[11]}});
  assign fits13 = (imm[20:12] == {9{imm[12]}});

  always_comb begin
    imm_bits = '0;
    legal    = 1'b0;
    case (cls)
      CLS_LOAD, CLS_ALUI, CLS_JALR: begin
        imm_bits[31:20] = imm[11:0];
        legal           = fits12;
      end
      CLS_STORE: begin
        imm_bits[31:25] = imm[11:5];
        imm_bits[11:7]  = imm[4:0];
        legal           = fits12;
      end
      CLS_BRANCH: begin
        imm_bits[31]    = imm[12];
        imm_bits[30:25] = imm[10:5];
        imm_bits[11:8]  = imm[4:1];
        imm_bits[7]     = imm[11];
        legal           = fits13 && !imm[0];
      end
      CLS_JAL: begin
        imm_bits[31]    = imm[20];
        imm_bits[30:21] = imm[10:1];
        imm_bits[20]    = imm[11];
        imm_bits[19:12] = imm[19:12];
        legal           = !imm[0];
      end
`ifdef INSTR_ENCODER_RTYPE_EN
      CLS_R: begin
        legal = 1'b1;
      end
`endif
      default: begin
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Program loader: packs decoded fields into RV32I words and writes them to sequential addresses.
// Define INSTR_ENCODER_RTYPE_EN to accept class R bundles; otherwise they are rejected.
module instr_encoder
  import riscv_isa_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        cls,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [20:0]       imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              err,
  output logic              full
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST = {ADDR_W{1'b1}};

  enc_state_t  state;
  enc_state_t  next_state;
  enc_fields_t fld;
  logic [31:0] imm_bits;
  logic        imm_legal;
  logic [31:0] word;
  logic        we_q;
  logic        accept;

`ifdef INSTR_ENCODER_RTYPE_EN
  logic [6:0] funct7_q;
`else
  logic unused_funct7;
  assign unused_funct7 = ^funct7;
`endif

  assign accept = (state == ST_IDLE) && in_ready && in_valid && !start;

  // A start pulse aborts a write already in flight.
  assign mem_we = we_q && !start;

  imm_packer u_imm_packer (
    .cls      (fld.cls),
    .imm      (fld.imm),
    .imm_bits (imm_bits),
    .legal    (imm_legal)
  );

  always_comb begin
    word      = imm_bits;
    word[6:0] = cls_opcode(fld.cls);
    case (fld.cls)
      CLS_LOAD, CLS_ALUI: begin
        word[19:15] = fld.rs1;
        word[14:12] = fld.funct3;
        word[11:7]  = fld.rd;
      end
      CLS_JALR: begin
        word[19:15] = fld.rs1;
        word[11:7]  = fld.rd;
      end
      CLS_STORE, CLS_BRANCH: begin
        word[24:20] = fld.rs2;
        word[19:15] = fld.rs1;
        word[14:12] = fld.funct3;
      end
      CLS_JAL: begin
        word[11:7] = fld.rd;
      end
`ifdef INSTR_ENCODER_RTYPE_EN
      CLS_R: begin
        word[31:25] = funct7_q;
        word[24:20] = fld.rs2;
        word[19:15] = fld.rs1;
        word[14:12] = fld.funct3;
        word[11:7]  = fld.rd;
      end
`endif
      default: begin
        word = '0;
      end
    endcase
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (accept) next_state = ST_ENC;
      ST_ENC:   next_state = imm_legal ? ST_WRITE : ST_IDLE;
      ST_WRITE: next_state = (mem_addr == LAST) ? ST_FULL : ST_IDLE;
      ST_FULL:  next_state = ST_FULL;
      default:  next_state = ST_IDLE;
    endcase
    if (start) next_state = ST_IDLE;
  end

  // Handshake and status flags are registered so they are all low while reset is held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      fld       <= '0;
      in_ready  <= 1'b0;
      we_q      <= 1'b0;
      full      <= 1'b0;
      mem_addr  <= BASE;
      mem_wdata <= '0;
      count     <= '0;
      err       <= 1'b0;
`ifdef INSTR_ENCODER_RTYPE_EN
      funct7_q  <= '0;
`endif
    end else begin
      state    <= next_state;
      in_ready <= (next_state == ST_IDLE);
      we_q     <= (next_state == ST_WRITE);
      full     <= (next_state == ST_FULL);
      if (accept) begin
        fld <= '{cls: cls, rd: rd, rs1: rs1, rs2: rs2, funct3: funct3, imm: imm};
`ifdef INSTR_ENCODER_RTYPE_EN
        funct7_q <= funct7;
`endif
      end
      if (start) begin
        mem_addr <= BASE;
        count    <= '0;
        err      <= 1'b0;
      end else begin
        case (state)
          ST_ENC: begin
            if (imm_legal) mem_wdata <= word;
            else           err       <= 1'b1;
          end
          ST_WRITE: begin
            count <= count + 1'b1;
            if (mem_addr != LAST) mem_addr <= mem_addr + 1'b1;
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder using a small capacity (ADDR_W=2) to reach the full region.
// A word-level model predicts every write; directed vectors pin literal encodings.
module tb_instr_encoder;
  import riscv_isa_pkg::*;

  localparam int ADDR_W = 2;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [2:0]        cls = '0;
  logic [4:0]        rd = '0;
  logic [4:0]        rs1 = '0;
  logic [4:0]        rs2 = '0;
  logic [2:0]        funct3 = '0;
  logic [6:0]        funct7 = '0;
  logic [20:0]       imm = '0;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [ADDR_W:0]   count;
  logic              err;
  logic              full;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(0)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .cls       (cls),
    .rd        (rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .funct3    (funct3),
    .funct7    (funct7),
    .imm       (imm),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .count     (count),
    .err       (err),
    .full      (full)
  );

  int checks = 0;
  int passes = 0;

  typedef struct {
    int          due;
    int          addr;
    logic [31:0] word;
  } exp_t;

  exp_t        expq[$];
  int          neg_idx = 0;
  int          m_addr = 0;
  int          m_count = 0;
  bit          m_err = 1'b0;
  bit          m_full = 1'b0;
  logic [31:0] last_wdata = '0;
  int          last_addr = -1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
  endtask

  // Encoding computed arithmetically from the RV32I field layouts.
  function automatic logic [31:0] model_encode(input logic [2:0] c, input logic [4:0] rdv, input logic [4:0] rs1v,
                                               input logic [4:0] rs2v, input logic [2:0] f3, input logic [6:0] f7,
                                               input logic [20:0] immv, output bit ok);
    int v;
    logic [31:0] u, r, s1, s2, fn3, w;
    v   = int'($signed(immv));
    u   = 32'(v);
    r   = 32'(rdv) << 7;
    s1  = 32'(rs1v) << 15;
    s2  = 32'(rs2v) << 20;
    fn3 = 32'(f3) << 12;
    ok  = 1'b0;
    w   = '0;
    case (c)
      3'd0: begin ok = (v >= -2048 && v <= 2047); w = ((u & 32'hFFF) << 20) | s1 | fn3 | r | 32'h03; end
      3'd1: begin ok = (v >= -2048 && v <= 2047); w = ((u & 32'hFFF) << 20) | s1 | fn3 | r | 32'h13; end
      3'd2: begin ok = (v >= -2048 && v <= 2047); w = ((u & 32'hFFF) << 20) | s1 | r | 32'h67; end
      3'd4: begin
        ok = (v >= -2048 && v <= 2047);
        w  = (((u >> 5) & 32'h7F) << 25) | s2 | s1 | fn3 | ((u & 32'h1F) << 7) | 32'h23;
      end
      3'd3: begin
        ok = (v >= -4096 && v <= 4094 && (v % 2) == 0);
        w  = (((u >> 12) & 32'h1) << 31) | (((u >> 5) & 32'h3F) << 25) | s2 | s1 | fn3 |
             (((u >> 1) & 32'hF) << 8) | (((u >> 11) & 32'h1) << 7) | 32'h63;
      end
      3'd5: begin
        ok = (v >= -1048576 && v <= 1048574 && (v % 2) == 0);
        w  = (((u >> 20) & 32'h1) << 31) | (((u >> 1) & 32'h3FF) << 21) | (((u >> 11) & 32'h1) << 20) |
             (((u >> 12) & 32'hFF) << 12) | r | 32'h6F;
      end
      3'd6: begin
`ifdef INSTR_ENCODER_RTYPE_EN
        ok = 1'b1;
`else
        ok = 1'b0;
`endif
        w = (32'(f7) << 25) | s2 | s1 | fn3 | r | 32'h33;
      end
      default: ok = 1'b0;
    endcase
    return w;
  endfunction

  // Model update and per-cycle write comparison, sampled mid-cycle.
  always @(negedge clk) begin : compare
    logic [31:0] w;
    bit ok;
    neg_idx++;
    if (reset || start) begin
      expq.delete();
      m_addr = 0; m_count = 0; m_err = 1'b0; m_full = 1'b0;
    end else if (in_valid && in_ready) begin
      w = model_encode(cls, rd, rs1, rs2, funct3, funct7, imm, ok);
      if (ok) begin
        expq.push_back('{due: neg_idx + 2, addr: m_addr, word: w});
        m_count++;
        if (m_addr == DEPTH - 1) m_full = 1'b1;
        else m_addr++;
      end else begin
        m_err = 1'b1;
      end
    end
    if (expq.size() > 0 && expq[0].due == neg_idx) begin
      checkOutput("mem_we strobe", 32'(mem_we), 32'd1);
      checkOutput("mem_addr", 32'(mem_addr), 32'(expq[0].addr));
      checkOutput("mem_wdata", mem_wdata, expq[0].word);
      last_wdata = mem_wdata;
      last_addr  = int'(mem_addr);
      void'(expq.pop_front());
    end else begin
      checkOutput("mem_we quiet", 32'(mem_we), 32'd0);
    end
  end

  task automatic applyStimulus(input logic [2:0] c, input logic [4:0] rdv, input logic [4:0] rs1v,
                               input logic [4:0] rs2v, input logic [2:0] f3, input logic [6:0] f7,
                               input logic [20:0] immv, output bit accepted);
    @(posedge clk); #1;
    cls = c; rd = rdv; rs1 = rs1v; rs2 = rs2v; funct3 = f3; funct7 = f7; imm = immv;
    in_valid = 1'b1;
    accepted = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (in_ready && !start) begin
        accepted = 1'b1;
        break;
      end
    end
    if (accepted) begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic waitDone();
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic pulseStart();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic checkStatus(input string tag);
    checkOutput({tag, " count"}, 32'(count), 32'(m_count));
    checkOutput({tag, " err"}, 32'(err), 32'(m_err));
    checkOutput({tag, " full"}, 32'(full), 32'(m_full));
    checkOutput({tag, " in_ready"}, 32'(in_ready), 32'(!m_full));
    checkOutput({tag, " mem_addr"}, 32'(mem_addr), 32'(m_addr));
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " in_ready"}, 32'(in_ready), 32'd0);
    checkOutput({tag, " mem_we"}, 32'(mem_we), 32'd0);
    checkOutput({tag, " mem_addr"}, 32'(mem_addr), 32'd0);
    checkOutput({tag, " mem_wdata"}, mem_wdata, 32'd0);
    checkOutput({tag, " count"}, 32'(count), 32'd0);
    checkOutput({tag, " err"}, 32'(err), 32'd0);
    checkOutput({tag, " full"}, 32'(full), 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  initial begin : main
    bit acc;
    bit ok;
    logic [31:0] mw;

    #1 reset = 1'b1;
    #2 checkResetValues("reset");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    mw = model_encode(CLS_ALUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 21'd10, ok);
    checkOutput("model ALUI", mw, 32'h00A00293);
    mw = model_encode(CLS_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 21'h1FFFFC, ok);
    checkOutput("model BRANCH", mw, 32'hFE000EE3);

    applyStimulus(CLS_ALUI, 5'd5, 5'd0, 5'd0, 3'b000, 7'd0, 21'd10, acc);
    checkOutput("ALUI accepted", 32'(acc), 32'd1);
    waitDone();
    checkOutput("ALUI word", last_wdata, 32'h00A00293);
    checkOutput("ALUI addr", 32'(last_addr), 32'd0);
    checkOutput("ALUI count", 32'(count), 32'd1);

    applyStimulus(CLS_STORE, 5'd0, 5'd2, 5'd5, 3'b010, 7'd0, 21'd8, acc);
    waitDone();
    checkOutput("STORE word", last_wdata, 32'h00512423);
    applyStimulus(CLS_BRANCH, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, 21'h1FFFFC, acc);
    waitDone();
    checkOutput("BRANCH word", last_wdata, 32'hFE000EE3);
    applyStimulus(CLS_JAL, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 21'd8, acc);
    waitDone();
    checkOutput("JAL word", last_wdata, 32'h008000EF);
    checkOutput("JAL addr", 32'(last_addr), 32'd3);
    checkOutput("full after 4", 32'(full), 32'd1);
    checkStatus("after fill");
    applyStimulus(CLS_ALUI, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 21'd1, acc);
    checkOutput("accepted while full", 32'(acc), 32'd0);
    checkOutput("addr held at end", 32'(mem_addr), 32'd3);

    pulseStart();
    checkOutput("start mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("start full", 32'(full), 32'd0);
    checkOutput("start in_ready", 32'(in_ready), 32'd1);
    checkOutput("start count", 32'(count), 32'd0);

    applyStimulus(CLS_BRANCH, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 21'd3, acc);
    waitDone();
    checkOutput("odd branch err", 32'(err), 32'd1);
    applyStimulus(CLS_ALUI, 5'd3, 5'd0, 5'd0, 3'b000, 7'd0, 21'd4096, acc);
    waitDone();
    applyStimulus(CLS_ALUI, 5'd3, 5'd0, 5'd0, 3'b000, 7'd0, 21'h1FF7FF, acc);
    waitDone();
    applyStimulus(CLS_JAL, 5'd3, 5'd0, 5'd0, 3'b000, 7'd0, 21'd7, acc);
    waitDone();
    applyStimulus(CLS_BRANCH, 5'd0, 5'd1, 5'd1, 3'b001, 7'd0, 21'd4096, acc);
    waitDone();
    applyStimulus(3'd7, 5'd3, 5'd0, 5'd0, 3'b000, 7'd0, 21'd0, acc);
    waitDone();
    checkOutput("illegal addr unchanged", 32'(mem_addr), 32'd0);
    checkOutput("illegal count", 32'(count), 32'd0);
    checkStatus("after illegal");

    applyStimulus(CLS_ALUI, 5'd5, 5'd0, 5'd0, 3'b000, 7'd0, 21'd10, acc);
    waitDone();
    checkOutput("legal after err word", last_wdata, 32'h00A00293);
    checkOutput("err sticky", 32'(err), 32'd1);
    applyStimulus(CLS_BRANCH, 5'd0, 5'd1, 5'd2, 3'b001, 7'd0, 21'd4094, acc);
    waitDone();
    applyStimulus(CLS_JAL, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, 21'h100000, acc);
    waitDone();
    checkOutput("JAL min word", last_wdata, 32'h8000006F);
    applyStimulus(CLS_JALR, 5'd1, 5'd2, 5'd0, 3'b111, 7'd0, 21'h1FF800, acc);
    waitDone();
    checkOutput("JALR f3 forced", last_wdata, 32'h800100E7);
    checkStatus("boundary");

    pulseStart();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(CLS_LOAD, 5'(i + 1), 5'd4, 5'd0, 3'b010, 7'd0, 21'(i * 4), acc);
      checkOutput("burst accept", 32'(acc), (i < 4) ? 32'd1 : 32'd0);
    end
    waitDone();
    checkStatus("burst");
    checkOutput("burst full", 32'(full), 32'd1);
    checkOutput("burst in_ready", 32'(in_ready), 32'd0);
    pulseStart();
    checkStatus("burst restart");

    applyStimulus(CLS_ALUI, 5'd6, 5'd1, 5'd0, 3'b000, 7'd0, 21'd1, acc);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    waitDone();
    checkOutput("start in ENC count", 32'(count), 32'd0);
    checkStatus("start in ENC");

    applyStimulus(CLS_ALUI, 5'd6, 5'd1, 5'd0, 3'b000, 7'd0, 21'd1, acc);
    @(posedge clk); #1;
    checkOutput("mem_we in WRITE", 32'(mem_we), 32'd1);
    reset = 1'b1;
    #1 checkResetValues("mid-write reset");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    applyStimulus(CLS_R, 5'd1, 5'd2, 5'd3, 3'b000, 7'b0100000, 21'd0, acc);
    waitDone();
`ifdef INSTR_ENCODER_RTYPE_EN
    checkOutput("R word", last_wdata, 32'h403100B3);
    checkOutput("R count", 32'(count), 32'd1);
`else
    checkOutput("R rejected err", 32'(err), 32'd1);
    checkOutput("R rejected count", 32'(count), 32'd0);
`endif
    checkStatus("R class");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
